// File: rtl/rx_lane_sync_pkg.sv
// rtl/rx_lane_sync_pkg.sv - shared PHY constants: comma symbol, lock count, lane FSM encoding
package rx_lane_sync_pkg;

  localparam logic [7:0] BC_SYMBOL_DEFAULT = 8'hBC;
  localparam int         BC_COUNT_DEFAULT  = 4;

  localparam logic [0:0] ST_INIT   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/rx_lane_sync_lane_sync.sv
// rtl/rx_lane_sync_lane_sync.sv - one lane: comma-lock FSM, saturating BC counter, output registers
import rx_lane_sync_pkg::*;

module lane_sync #(
  parameter logic [7:0] BC_SYMBOL = BC_SYMBOL_DEFAULT,
  parameter int         BC_COUNT  = BC_COUNT_DEFAULT
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] LP_LOCK = 4'(BC_COUNT);

  logic [0:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       w_is_bc;

  assign w_is_bc = (data_in == BC_SYMBOL);

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_cnt   <= 4'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_data  <= 8'h00;
          r_valid <= 1'b0;
          if (w_is_bc) begin
            // Lock on the edge sampling the final comma; counter parks at the lock value.
            if (r_cnt == LP_LOCK - 4'd1) begin
              r_state <= ST_ACTIVE;
              r_cnt   <= LP_LOCK;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            r_cnt <= 4'd0;
          end
        end
        ST_ACTIVE: begin
          if (w_is_bc) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
          end else begin
            r_data  <= data_in;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= 4'd0;
          r_data  <= 8'h00;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = (r_state == ST_ACTIVE);

endmodule

// File: rtl/rx_lane_sync.sv
// rtl/rx_lane_sync.sv - two independent lane synchronisers plus combined active flag
import rx_lane_sync_pkg::*;

module rx_lane_sync #(
  parameter logic [7:0] BC_SYMBOL = BC_SYMBOL_DEFAULT,
  parameter int         BC_COUNT  = BC_COUNT_DEFAULT
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       active0,
  output logic       active1,
  output logic       active_out
);

  lane_sync #(.BC_SYMBOL(BC_SYMBOL), .BC_COUNT(BC_COUNT)) u_lane0 (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_in   (data_in0),
    .data_out  (data_out0),
    .valid_out (valid_out0),
    .active    (active0)
  );

  lane_sync #(.BC_SYMBOL(BC_SYMBOL), .BC_COUNT(BC_COUNT)) u_lane1 (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_in   (data_in1),
    .data_out  (data_out1),
    .valid_out (valid_out1),
    .active    (active1)
  );

  assign active_out = active0 & active1;

endmodule

// File: tb/tb_rx_lane_sync.sv
// tb/tb_rx_lane_sync.sv - directed scoreboard bench for rx_lane_sync
module tb_rx_lane_sync;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic [7:0] data_in0, data_in1;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, active0, active1, active_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d0;
    logic       v0;
    logic       a0;
    logic [7:0] d1;
    logic       v1;
    logic       a1;
  } exp_t;

  exp_t q[$];

  rx_lane_sync dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .active0    (active0),
    .active1    (active1),
    .active_out (active_out)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input int step, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed %0h expected %0h", tag, step, obs, expv);
    end
  endtask

  // Drive one byte per lane, queue the expected post-edge outputs, then compare after the edge.
  task automatic cyc(input int step, input logic rst, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] e_d0, input logic e_v0, input logic e_a0,
                     input logic [7:0] e_d1, input logic e_v1, input logic e_a1);
    exp_t e;
    reset    = rst;
    data_in0 = b0;
    data_in1 = b1;
    e.d0 = e_d0; e.v0 = e_v0; e.a0 = e_a0;
    e.d1 = e_d1; e.v1 = e_v1; e.a1 = e_a1;
    q.push_back(e);
    @(posedge clk_2f);
    #1;
    e = q.pop_front();
    chk("data_out0",  step, data_out0,         e.d0);
    chk("valid_out0", step, {7'd0, valid_out0}, {7'd0, e.v0});
    chk("active0",    step, {7'd0, active0},    {7'd0, e.a0});
    chk("data_out1",  step, data_out1,         e.d1);
    chk("valid_out1", step, {7'd0, valid_out1}, {7'd0, e.v1});
    chk("active1",    step, {7'd0, active1},    {7'd0, e.a1});
    chk("active_out", step, {7'd0, active_out}, {7'd0, e.a0 & e.a1});
  endtask

  initial begin
    reset    = 1'b0;
    data_in0 = 8'h55;
    data_in1 = 8'h55;

    // Reset held three cycles, then one released cycle of non-comma input.
    cyc(1, 1'b0, 8'h55, 8'h55, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(2, 1'b0, 8'h55, 8'h55, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(3, 1'b0, 8'h55, 8'h55, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(4, 1'b1, 8'h55, 8'h55, 8'h00, 0, 0, 8'h00, 0, 0);

    // Lane0 locks on 4th BC; lane1 count broken by 8'h33.
    cyc(5,  1'b1, BC,    BC,    8'h00, 0, 0, 8'h00, 0, 0);
    cyc(6,  1'b1, BC,    BC,    8'h00, 0, 0, 8'h00, 0, 0);
    cyc(7,  1'b1, BC,    BC,    8'h00, 0, 0, 8'h00, 0, 0);
    cyc(8,  1'b1, BC,    8'h33, 8'h00, 0, 1, 8'h00, 0, 0);
    cyc(9,  1'b1, 8'h11, BC,    8'h11, 1, 1, 8'h00, 0, 0);
    cyc(10, 1'b1, 8'h22, BC,    8'h22, 1, 1, 8'h00, 0, 0);
    cyc(11, 1'b1, 8'hA0, BC,    8'hA0, 1, 1, 8'h00, 0, 0);
    cyc(12, 1'b1, BC,    BC,    8'h00, 0, 1, 8'h00, 0, 1);
    cyc(13, 1'b1, 8'hA1, 8'hF0, 8'hA1, 1, 1, 8'hF0, 1, 1);
    cyc(14, 1'b1, 8'hF0, 8'hF0, 8'hF0, 1, 1, 8'hF0, 1, 1);

    // Mid-stream reset discards the sampled byte; relock needs four fresh BCs.
    cyc(15, 1'b0, 8'hF0, 8'hF0, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(16, 1'b1, BC,    BC,    8'h00, 0, 0, 8'h00, 0, 0);
    cyc(17, 1'b1, BC,    BC,    8'h00, 0, 0, 8'h00, 0, 0);
    cyc(18, 1'b1, BC,    BC,    8'h00, 0, 0, 8'h00, 0, 0);
    cyc(19, 1'b1, BC,    BC,    8'h00, 0, 1, 8'h00, 0, 1);

    // Long comma run: counter saturates, lock stays sticky.
    for (int i = 0; i < 20; i++)
      cyc(20 + i, 1'b1, BC, BC, 8'h00, 0, 1, 8'h00, 0, 1);

    // Back-to-back payload, no bubbles, lanes carrying different bytes.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] p0, p1;
      p0 = 8'(i * 3 + 1);
      p1 = 8'hC0 + 8'(i);
      cyc(40 + i, 1'b1, p0, p1, p0, 1, 1, p1, 1, 1);
    end

    // Reset then lock only lane1; lane0 kept out of lock by a non-BC in the run.
    cyc(48, 1'b0, BC, BC, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(49, 1'b1, BC,    BC, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(50, 1'b1, BC,    BC, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(51, 1'b1, 8'h00, BC, 8'h00, 0, 0, 8'h00, 0, 0);
    cyc(52, 1'b1, BC,    BC, 8'h00, 0, 0, 8'h00, 0, 1);
    cyc(53, 1'b1, 8'h77, 8'h5A, 8'h00, 0, 0, 8'h5A, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
